// File: rtl/vend_arbiter_if.sv
// Coin, dispenser and payout signals between the two-slot vending front end
// and its environment. The arbiter connects through the slave modport.
interface vend_arbiter_if;
    logic [1:0] coin_a;
    logic [1:0] coin_b;
    logic       disp_ack;
    logic       disp_req;
    logic       disp_sel;
    logic       change_a;
    logic       change_b;
    logic       reject_a;
    logic       reject_b;

    modport master (
        output coin_a, coin_b, disp_ack,
        input  disp_req, disp_sel, change_a, change_b, reject_a, reject_b
    );

    modport slave (
        input  coin_a, coin_b, disp_ack,
        output disp_req, disp_sel, change_a, change_b, reject_a, reject_b
    );
endinterface

// File: rtl/vend_arbiter.sv
// Two-slot credit keeper with a round-robin grant of one shared dispenser,
// a req/ack handshake, and 5-unit change payout of any overshoot.
module vend_arbiter #(
    parameter int unsigned PRICE    = 15,
    parameter int unsigned CREDIT_W = 5
) (
    input logic           clk,
    input logic           rst,
    vend_arbiter_if.slave bus
);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] TEN_C   = CREDIT_W'(10);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_CHANGE = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [1:0][CREDIT_W-1:0]   credit_q, credit_d;
    logic                       last_srv_q, last_srv_d;
    logic                       disp_req_q, disp_req_d;
    logic                       disp_sel_q, disp_sel_d;
    logic [1:0]                 change_q, change_d;
    logic [1:0]                 reject_q, reject_d;

    logic [1:0][1:0]            coin;
    logic [1:0]                 pending;
    logic [1:0]                 accepting;
    logic                       busy;

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        last_srv_d = last_srv_q;
        disp_sel_d = disp_sel_q;
        disp_req_d = 1'b0;
        change_d   = '0;
        reject_d   = '0;
        pending    = '0;
        accepting  = '0;
        coin[0]    = bus.coin_a;
        coin[1]    = bus.coin_b;
        busy       = (state_q != S_IDLE);

        // Coin intake: the granted slot is locked out until it is released.
        for (int i = 0; i < 2; i++) begin
            pending[i]   = (credit_q[i] >= PRICE_C);
            accepting[i] = !pending[i] && !(busy && (disp_sel_q == 1'(i)));
            unique case (coin[i])
                2'b01: begin
                    if (accepting[i]) credit_d[i] = credit_q[i] + FIVE_C;
                    else              reject_d[i] = 1'b1;
                end
                2'b10: begin
                    if (accepting[i]) credit_d[i] = credit_q[i] + TEN_C;
                    else              reject_d[i] = 1'b1;
                end
                2'b11:   reject_d[i] = 1'b1;
                default: ;
            endcase
        end

        // Dispenser grant, handshake and change payout for the selected slot.
        unique case (state_q)
            S_IDLE: begin
                if (pending[0] || pending[1]) begin
                    disp_sel_d = (pending[0] && pending[1]) ? ~last_srv_q : pending[1];
                    disp_req_d = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.disp_ack) begin
                    credit_d[disp_sel_q] = credit_q[disp_sel_q] - PRICE_C;
                    last_srv_d           = disp_sel_q;
                    if (credit_d[disp_sel_q] != '0) begin
                        change_d[disp_sel_q] = 1'b1;
                        state_d              = S_CHANGE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    disp_req_d = 1'b1;
                end
            end
            S_CHANGE: begin
                credit_d[disp_sel_q] = credit_q[disp_sel_q] - FIVE_C;
                if (credit_d[disp_sel_q] == '0) state_d = S_IDLE;
                else                            change_d[disp_sel_q] = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            last_srv_q <= 1'b1;
            disp_req_q <= 1'b0;
            disp_sel_q <= 1'b0;
            change_q   <= '0;
            reject_q   <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            last_srv_q <= last_srv_d;
            disp_req_q <= disp_req_d;
            disp_sel_q <= disp_sel_d;
            change_q   <= change_d;
            reject_q   <= reject_d;
        end
    end

    assign bus.disp_req = disp_req_q;
    assign bus.disp_sel = disp_sel_q;
    assign bus.change_a = change_q[0];
    assign bus.change_b = change_q[1];
    assign bus.reject_a = reject_q[0];
    assign bus.reject_b = reject_q[1];
endmodule

// File: tb/tb_vend_arbiter.sv
// Bench for vend_arbiter: hand-derived vector table for the listed scenarios,
// then random coins/acks/resets against a per-slot credit/payout model.
module tb_vend_arbiter;
    localparam int PRICE = 15;

    logic clk = 1'b0;
    logic rst;
    vend_arbiter_if bus ();

    vend_arbiter #(.PRICE(PRICE), .CREDIT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Output word layout: {disp_req, disp_sel, change_a, change_b, reject_a, reject_b}
    typedef struct {
        logic       rst;
        logic [1:0] ca;
        logic [1:0] cb;
        logic       ack;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int m_cred[2];
    int m_g;
    bit m_req;
    int m_chg;
    int m_last;
    int m_sel;

    task automatic add(input logic r, input logic [1:0] ca, input logic [1:0] cb,
                       input logic ack, input logic [5:0] exp);
        vec_t v;
        v.rst = r; v.ca = ca; v.cb = cb; v.ack = ack; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic apply(input logic r, input logic [1:0] ca, input logic [1:0] cb,
                         input logic ack, output logic [5:0] got);
        rst          = r;
        bus.coin_a   = ca;
        bus.coin_b   = cb;
        bus.disp_ack = ack;
        @(posedge clk);
        #1;
        got = {bus.disp_req, bus.disp_sel, bus.change_a, bus.change_b,
               bus.reject_a, bus.reject_b};
    endtask

    task automatic check(input string name, input int idx, input logic [5:0] got,
                         input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: {req,sel,chg_a,chg_b,rej_a,rej_b} got %b want %b",
                     name, idx, got, exp);
        end
    endtask

    // One clock edge of the vending rules, expressed on integer credits
    task automatic model_step(input logic r, input logic [1:0] ca, input logic [1:0] cb,
                              input logic ack, output logic [5:0] exp);
        int  pre[2];
        int  c[2];
        bit  rej[2];
        bit  busy;
        bit  acc;
        if (r) begin
            m_cred[0] = 0; m_cred[1] = 0;
            m_g = -1; m_req = 0; m_chg = 0; m_last = 1; m_sel = 0;
            exp = '0;
        end else begin
            pre[0] = m_cred[0]; pre[1] = m_cred[1];
            c[0] = int'(ca); c[1] = int'(cb);
            busy = m_req || (m_chg > 0);
            for (int x = 0; x < 2; x++) begin
                acc    = (pre[x] < PRICE) && !(busy && m_g == x);
                rej[x] = (c[x] != 0) && ((c[x] == 3) || !acc);
                if (!rej[x] && c[x] != 0) m_cred[x] += 5 * c[x];
            end
            if (m_req) begin
                if (ack) begin
                    m_cred[m_g] -= PRICE;
                    m_last = m_g;
                    m_req  = 0;
                    m_chg  = m_cred[m_g] / 5;
                end
            end else if (m_chg > 0) begin
                m_cred[m_g] -= 5;
                m_chg--;
            end else if (pre[0] >= PRICE || pre[1] >= PRICE) begin
                if (pre[0] >= PRICE && pre[1] >= PRICE) m_g = 1 - m_last;
                else                                    m_g = (pre[1] >= PRICE) ? 1 : 0;
                m_sel = m_g;
                m_req = 1;
            end
            exp = {m_req, m_sel[0], (m_chg > 0 && m_g == 0), (m_chg > 0 && m_g == 1),
                   rej[0], rej[1]};
        end
    endtask

    function automatic logic [1:0] rand_coin();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 5) return 2'b00;
        if (r <= 7) return 2'b01;
        if (r == 8) return 2'b10;
        return 2'b11;
    endfunction

    initial begin
        logic [5:0] got;
        logic [5:0] exp;
        logic       r, ack;
        logic [1:0] ca, cb;

        rst = 1'b1; bus.coin_a = 2'b00; bus.coin_b = 2'b00; bus.disp_ack = 1'b0;

        // A: 5 then 10, ack two cycles after request, no change
        add(1, 2'b00, 2'b00, 0, 6'b00_00_00);
        add(0, 2'b01, 2'b00, 0, 6'b00_00_00);
        add(0, 2'b10, 2'b00, 0, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b10_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b10_00_00);
        add(0, 2'b00, 2'b00, 1, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 1, 6'b00_00_00);
        // A: 10 then 10, one change pulse after ack
        add(0, 2'b10, 2'b00, 0, 6'b00_00_00);
        add(0, 2'b10, 2'b00, 0, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b10_00_00);
        add(0, 2'b00, 2'b00, 1, 6'b00_10_00);
        add(0, 2'b00, 2'b00, 0, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b00_00_00);
        // Tie after reset: A first, then B, then A again
        add(1, 2'b00, 2'b00, 0, 6'b00_00_00);
        add(0, 2'b01, 2'b01, 0, 6'b00_00_00);
        add(0, 2'b10, 2'b10, 0, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b10_00_00);
        add(0, 2'b00, 2'b00, 1, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b11_00_00);
        add(0, 2'b00, 2'b00, 1, 6'b01_00_00);
        add(0, 2'b10, 2'b10, 0, 6'b01_00_00);
        add(0, 2'b01, 2'b01, 0, 6'b01_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b10_00_00);
        // A waiting for ack: extra A coin and invalid B coin both rejected
        add(0, 2'b01, 2'b11, 0, 6'b10_00_11);
        add(0, 2'b00, 2'b00, 0, 6'b10_00_00);
        add(0, 2'b00, 2'b00, 1, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b11_00_00);
        add(0, 2'b00, 2'b00, 1, 6'b01_00_00);
        // B collects 5+5 while A is served; not requested until 15
        add(0, 2'b10, 2'b00, 0, 6'b01_00_00);
        add(0, 2'b01, 2'b00, 0, 6'b01_00_00);
        add(0, 2'b00, 2'b01, 0, 6'b10_00_00);
        add(0, 2'b00, 2'b01, 0, 6'b10_00_00);
        add(0, 2'b00, 2'b00, 1, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b00_00_00);
        add(0, 2'b00, 2'b01, 0, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b11_00_00);
        add(0, 2'b00, 2'b00, 1, 6'b01_00_00);
        // Reset with ack in REQ at credit 20: no payout, nothing requested
        add(0, 2'b10, 2'b00, 0, 6'b01_00_00);
        add(0, 2'b10, 2'b00, 0, 6'b01_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b10_00_00);
        add(1, 2'b00, 2'b00, 1, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b00_00_00);
        // B overshoot: change_b pulse, B coin rejected during payout
        add(0, 2'b00, 2'b10, 0, 6'b00_00_00);
        add(0, 2'b00, 2'b10, 0, 6'b00_00_00);
        add(0, 2'b00, 2'b00, 0, 6'b11_00_00);
        add(0, 2'b00, 2'b00, 1, 6'b01_01_00);
        add(0, 2'b00, 2'b01, 0, 6'b01_00_01);
        add(0, 2'b00, 2'b00, 0, 6'b01_00_00);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].ca, tbl[i].cb, tbl[i].ack, got);
            check("table", i, got, tbl[i].exp);
        end

        for (int i = 0; i < 4000; i++) begin
            r   = (i == 0) || ($urandom_range(0, 299) == 0);
            ca  = rand_coin();
            cb  = rand_coin();
            ack = ($urandom_range(0, 3) == 0);
            apply(r, ca, cb, ack, got);
            model_step(r, ca, cb, ack, exp);
            check("random", i, got, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
